// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - PC source encodings, inter-stage register bit indices, FSM state enum
//   - stage_ctl_t: per-lane enable/clear bundle for the four stage registers
//   - flush_ctl(): enable/clear pattern for an exception flush
package pipe_stage_ctrl_pkg;

    localparam int unsigned NUM_STG = 4;

    localparam int unsigned STG_IF_ID  = 0;
    localparam int unsigned STG_ID_EX  = 1;
    localparam int unsigned STG_EX_MEM = 2;
    localparam int unsigned STG_MEM_WB = 3;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_EXC = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_EXC_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [NUM_STG-1:0] ena_m;
        logic [NUM_STG-1:0] ena_s;
        logic [NUM_STG-1:0] clr_m;
        logic [NUM_STG-1:0] clr_s;
    } stage_ctl_t;

    // Flush everything up to M; mem_wb is killed only for the faulting lane
    // and, because the slave is younger, a master fault also kills the slave.
    function automatic stage_ctl_t flush_ctl(input logic exc_m, input logic exc_s);
        stage_ctl_t c;
        c.clr_m = {exc_m, 3'b111};
        c.clr_s = {exc_m | exc_s, 3'b111};
        c.ena_m = ~c.clr_m;
        c.ena_s = ~c.clr_s;
        return c;
    endfunction

endpackage

// File: rtl/pipe_div_timer.sv
// Divide latency counter.
//   clk, rst     : clock, async active-low reset
//   load         : start a divide (count <= DIV_CYCLES-1)
//   dec          : decrement by one (hold when low, i.e. frozen)
//   clr          : abort, return count to zero
//   cnt_zero_c   : count has reached zero
module pipe_div_timer #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    input  logic clr,
    output logic cnt_zero_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(DIV_CYCLES - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt_zero_c = (cnt_q == '0);

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Central stall/flush sequencer for the dual-issue 5-stage pipeline.
// All controls are combinational from state and inputs and act on the
// coming clock edge.
//   clk, rst                 : clock, async active-low reset
//   icache_stall/dcache_stall: fetch / memory miss pending
//   load_use, br_flush       : ID hazard, EX master-lane redirect
//   div_start                : divide entering EX
//   M_*_except_hit           : exception at M per lane
//   ena_m/ena_s, clr_m/clr_s : per-lane stage register enables / clears
//                              (bit0 if_id .. bit3 mem_wb)
//   pc_ena, pc_sel           : PC update enable and source
//   div_cancel, div_busy     : divider abort pulse, divide stall active
// Optional: PIPE_PERF_CNT_EN adds perf_stall_cyc / perf_flush_cnt.
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         icache_stall,
    input  logic         dcache_stall,
    input  logic         load_use,
    input  logic         br_flush,
    input  logic         div_start,
    input  logic         M_master_except_hit,
    input  logic         M_slave_except_hit,
    output logic [3:0]   ena_m,
    output logic [3:0]   ena_s,
    output logic [3:0]   clr_m,
    output logic [3:0]   clr_s,
    output logic         pc_ena,
    output logic [1:0]   pc_sel,
    output logic         div_cancel,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]  perf_stall_cyc,
    output logic [31:0]  perf_flush_cnt,
`endif
    output logic         div_busy
);

    state_e     state_q, state_d;
    logic [1:0] exc_q, exc_d;
    stage_ctl_t ctl_c;
    logic       pc_ena_c;
    logic [1:0] pc_sel_c;
    logic       div_cancel_c;
    logic       flush_exc_c;
    logic       t_load, t_dec, t_clr;
    logic       cnt_zero_c;
    logic       exc_live;

    assign exc_live = M_master_except_hit | M_slave_except_hit;

    pipe_div_timer #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (t_load),
        .dec        (t_dec),
        .clr        (t_clr),
        .cnt_zero_c (cnt_zero_c)
    );

    // State and latched exception vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            exc_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    // Next state and controls, highest-priority event first
    always_comb begin
        state_d      = state_q;
        exc_d        = exc_q;
        ctl_c.ena_m  = 4'hF;
        ctl_c.ena_s  = 4'hF;
        ctl_c.clr_m  = 4'h0;
        ctl_c.clr_s  = 4'h0;
        pc_ena_c     = 1'b1;
        pc_sel_c     = PC_SEQ;
        div_cancel_c = 1'b0;
        flush_exc_c  = 1'b0;
        t_load       = 1'b0;
        t_dec        = 1'b0;
        t_clr        = 1'b0;

        if (state_q == ST_EXC_HOLD) begin
            // Live exceptions ignored; replay the latched vector once M drains
            if (dcache_stall) begin
                ctl_c.ena_m = 4'h0;
                ctl_c.ena_s = 4'h0;
                pc_ena_c    = 1'b0;
            end else begin
                ctl_c       = flush_ctl(exc_q[1], exc_q[0]);
                pc_sel_c    = PC_EXC;
                flush_exc_c = 1'b1;
                exc_d       = 2'b00;
                state_d     = ST_RUN;
            end
        end else if (exc_live) begin
            if (dcache_stall) begin
                ctl_c.ena_m = 4'h0;
                ctl_c.ena_s = 4'h0;
                pc_ena_c    = 1'b0;
                exc_d       = {M_master_except_hit, M_slave_except_hit};
                state_d     = ST_EXC_HOLD;
            end else begin
                ctl_c       = flush_ctl(M_master_except_hit, M_slave_except_hit);
                pc_sel_c    = PC_EXC;
                flush_exc_c = 1'b1;
                state_d     = ST_RUN;
            end
            if (state_q == ST_DIV_BUSY) begin
                div_cancel_c = 1'b1;
                t_clr        = 1'b1;
            end
        end else if (dcache_stall) begin
            // Freeze up to M, bubble into W so the stalled op writes back once
            ctl_c.ena_m[2:0] = 3'b000;
            ctl_c.ena_s[2:0] = 3'b000;
            ctl_c.clr_m[STG_MEM_WB] = 1'b1;
            ctl_c.clr_s[STG_MEM_WB] = 1'b1;
            pc_ena_c = 1'b0;
        end else if (state_q == ST_DIV_BUSY) begin
            if (cnt_zero_c) begin
                state_d = ST_RUN;
            end else begin
                ctl_c.ena_m[1:0] = 2'b00;
                ctl_c.ena_s[1:0] = 2'b00;
                ctl_c.clr_m[STG_EX_MEM] = 1'b1;
                ctl_c.clr_s[STG_EX_MEM] = 1'b1;
                pc_ena_c = 1'b0;
                t_dec    = 1'b1;
            end
        end else if (div_start) begin
            t_load  = 1'b1;
            state_d = ST_DIV_BUSY;
        end else if (br_flush) begin
            if (icache_stall) begin
                // Hold everything so the redirect is retried after the miss
                ctl_c.ena_m = 4'h0;
                ctl_c.ena_s = 4'h0;
                pc_ena_c    = 1'b0;
            end else begin
                ctl_c.clr_m[STG_IF_ID] = 1'b1;
                ctl_c.clr_s[STG_IF_ID] = 1'b1;
                pc_sel_c = PC_BR;
            end
        end else if (icache_stall || load_use) begin
            pc_ena_c = 1'b0;
            if (load_use) begin
                ctl_c.ena_m[STG_IF_ID] = 1'b0;
                ctl_c.ena_s[STG_IF_ID] = 1'b0;
                ctl_c.clr_m[STG_ID_EX] = 1'b1;
                ctl_c.clr_s[STG_ID_EX] = 1'b1;
            end else begin
                ctl_c.clr_m[STG_IF_ID] = 1'b1;
                ctl_c.clr_s[STG_IF_ID] = 1'b1;
            end
        end

        // Reset overrides everything combinationally
        if (!rst) begin
            ctl_c.ena_m  = 4'h0;
            ctl_c.ena_s  = 4'h0;
            ctl_c.clr_m  = 4'hF;
            ctl_c.clr_s  = 4'hF;
            pc_ena_c     = 1'b0;
            pc_sel_c     = PC_SEQ;
            div_cancel_c = 1'b0;
            flush_exc_c  = 1'b0;
        end
    end

    assign ena_m      = ctl_c.ena_m;
    assign ena_s      = ctl_c.ena_s;
    assign clr_m      = ctl_c.clr_m;
    assign clr_s      = ctl_c.clr_s;
    assign pc_ena     = pc_ena_c;
    assign pc_sel     = pc_sel_c;
    assign div_cancel = div_cancel_c;
    assign div_busy   = (state_q == ST_DIV_BUSY);

`ifdef PIPE_PERF_CNT_EN
    // Saturating stall-cycle and exception-flush counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_ena_c && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (flush_exc_c && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: each stimulus cycle queues its
// hand-written expected controls; a monitor pops and compares on negedge.
module tb_pipe_stage_ctrl;
    import pipe_stage_ctrl_pkg::*;

    localparam int unsigned DIV = 12;

    localparam logic [6:0] N  = 7'h00;
    localparam logic [6:0] IC = 7'h40;
    localparam logic [6:0] DC = 7'h20;
    localparam logic [6:0] LU = 7'h10;
    localparam logic [6:0] BR = 7'h08;
    localparam logic [6:0] DS = 7'h04;
    localparam logic [6:0] XM = 7'h02;
    localparam logic [6:0] XS = 7'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       icache_stall = 1'b0, dcache_stall = 1'b0, load_use = 1'b0;
    logic       br_flush = 1'b0, div_start = 1'b0;
    logic       M_master_except_hit = 1'b0, M_slave_except_hit = 1'b0;
    logic [3:0] ena_m, ena_s, clr_m, clr_s;
    logic       pc_ena, div_cancel, div_busy;
    logic [1:0] pc_sel;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    typedef struct {
        logic [3:0] em, es, cm, cs;
        logic       pe;
        logic [1:0] ps;
        logic       dcn, db;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(
        .DIV_CYCLES (DIV),
        .CNT_W      (6)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_stall        (icache_stall),
        .dcache_stall        (dcache_stall),
        .load_use            (load_use),
        .br_flush            (br_flush),
        .div_start           (div_start),
        .M_master_except_hit (M_master_except_hit),
        .M_slave_except_hit  (M_slave_except_hit),
        .ena_m               (ena_m),
        .ena_s               (ena_s),
        .clr_m               (clr_m),
        .clr_s               (clr_s),
        .pc_ena              (pc_ena),
        .pc_sel              (pc_sel),
        .div_cancel          (div_cancel),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cyc      (perf_stall_cyc),
        .perf_flush_cnt      (perf_flush_cnt),
`endif
        .div_busy            (div_busy)
    );

    function automatic exp_t mk(input logic [3:0] em, input logic [3:0] es,
                                input logic [3:0] cm, input logic [3:0] cs,
                                input logic pe, input logic [1:0] ps,
                                input logic dcn, input logic db, input string nm);
        exp_t e;
        e.em = em; e.es = es; e.cm = cm; e.cs = cs;
        e.pe = pe; e.ps = ps; e.dcn = dcn; e.db = db; e.nm = nm;
        return e;
    endfunction

    task automatic drive(input logic [6:0] iv);
        {icache_stall, dcache_stall, load_use, br_flush, div_start,
         M_master_except_hit, M_slave_except_hit} = iv;
    endtask

    task automatic step(input logic r, input logic [6:0] iv, input exp_t e);
        @(posedge clk);
        #1;
        rst = r;
        drive(iv);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every cycle that has a queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if ({ena_m, ena_s, clr_m, clr_s, pc_ena, pc_sel, div_cancel, div_busy} !==
                    {e.em, e.es, e.cm, e.cs, e.pe, e.ps, e.dcn, e.db}) begin
                    $display("FAIL %s @%0t: got ena_m=%h ena_s=%h clr_m=%h clr_s=%h pc_ena=%b pc_sel=%0d div_cancel=%b div_busy=%b | exp ena_m=%h ena_s=%h clr_m=%h clr_s=%h pc_ena=%b pc_sel=%0d div_cancel=%b div_busy=%b",
                             e.nm, $time, ena_m, ena_s, clr_m, clr_s, pc_ena, pc_sel, div_cancel, div_busy,
                             e.em, e.es, e.cm, e.cs, e.pe, e.ps, e.dcn, e.db);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        exp_t e_rst, e_def, e_def_db, e_busy, e_dc, e_dc_db, e_hold;
        exp_t e_fl_s, e_fl_m_div, e_br, e_ic, e_lu, e_iclu;

        e_rst      = mk(4'h0, 4'h0, 4'hF, 4'hF, 1'b0, PC_SEQ, 1'b0, 1'b0, "reset");
        e_def      = mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b1, PC_SEQ, 1'b0, 1'b0, "default");
        e_def_db   = mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b1, PC_SEQ, 1'b0, 1'b1, "div_done");
        e_busy     = mk(4'hC, 4'hC, 4'h4, 4'h4, 1'b0, PC_SEQ, 1'b0, 1'b1, "div_busy");
        e_dc       = mk(4'h8, 4'h8, 4'h8, 4'h8, 1'b0, PC_SEQ, 1'b0, 1'b0, "dcache");
        e_dc_db    = mk(4'h8, 4'h8, 4'h8, 4'h8, 1'b0, PC_SEQ, 1'b0, 1'b1, "dcache_in_div");
        e_hold     = mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, PC_SEQ, 1'b0, 1'b0, "hold_all");
        e_fl_s     = mk(4'h8, 4'h0, 4'h7, 4'hF, 1'b1, PC_EXC, 1'b0, 1'b0, "flush_slave");
        e_fl_m_div = mk(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, PC_EXC, 1'b1, 1'b1, "flush_master_div");
        e_br       = mk(4'hF, 4'hF, 4'h1, 4'h1, 1'b1, PC_BR,  1'b0, 1'b0, "branch");
        e_ic       = mk(4'hF, 4'hF, 4'h1, 4'h1, 1'b0, PC_SEQ, 1'b0, 1'b0, "icache");
        e_lu       = mk(4'hE, 4'hE, 4'h2, 4'h2, 1'b0, PC_SEQ, 1'b0, 1'b0, "load_use");
        e_iclu     = mk(4'hE, 4'hE, 4'h2, 4'h2, 1'b0, PC_SEQ, 1'b0, 1'b0, "icache_load_use");

        // Reset values, then idle
        step(1'b0, N, e_rst);
        step(1'b0, XM | DC | BR, e_rst);
        for (int i = 0; i < 10; i++) step(1'b1, N, e_def);

        // Full divide with a 2-cycle dcache freeze in the middle
        step(1'b1, DS, e_def);
        for (int i = 0; i < 5; i++) step(1'b1, N, e_busy);
        step(1'b1, DC, e_dc_db);
        step(1'b1, DC | BR, e_dc_db);
        for (int i = 0; i < 6; i++) step(1'b1, N, e_busy);
        step(1'b1, N, e_def_db);
        step(1'b1, N, e_def);

        // Master exception while the divide count is 10
        step(1'b1, DS, e_def);
        step(1'b1, N, e_busy);
        step(1'b1, XM, e_fl_m_div);
        step(1'b1, N, e_def);

        // Slave exception during a 3-cycle dcache stall, then latched flush
        step(1'b1, XS | DC, e_hold);
        step(1'b1, XS | DC, e_hold);
        step(1'b1, XM | DC, e_hold);
        step(1'b1, N, e_fl_s);
        step(1'b1, N, e_def);

        // Live slave exception without stall; dcache beating a branch
        step(1'b1, XS, e_fl_s);
        step(1'b1, DC | BR, e_dc);
        step(1'b1, N, e_def);

        // Branch held by icache miss, then redirect with load_use ignored
        step(1'b1, BR | IC, e_hold);
        step(1'b1, BR | IC | LU, e_hold);
        step(1'b1, BR | LU, e_br);
        step(1'b1, IC, e_ic);
        step(1'b1, LU, e_lu);
        step(1'b1, IC | LU, e_iclu);
        step(1'b1, BR, e_br);
        step(1'b1, N, e_def);

        // Reset held across a cycle while in EXC_HOLD
        step(1'b1, XM | DC, e_hold);
        step(1'b1, DC, e_hold);
        step(1'b0, DC, e_rst);
        step(1'b0, N, e_rst);
        step(1'b1, N, e_def);

        // Short reset pulse between clock edges while in EXC_HOLD
        step(1'b1, XS | DC, e_hold);
        step(1'b1, DC, e_hold);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(N);
        #2;
        rst = 1'b1;
        exp_q.push_back(mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b1, PC_SEQ, 1'b0, 1'b0, "async_reset_pulse"));
        step(1'b1, N, e_def);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
